// File: rtl/coproc_pkg.sv
// Shared widths, FSM state encoding and helpers for the coprocessor scheduler.
package coproc_pkg;

  localparam int RO_W        = 8;
  localparam int CHK_W       = 2;
  localparam int LAT_DEFAULT = 2;
  localparam int CNT_W       = 4;
  localparam int GCNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [RO_W-1:0]  ro;
    logic [CHK_W-1:0] check;
  } op_t;

  function automatic logic [GCNT_W-1:0] sat_inc(input logic [GCNT_W-1:0] v);
    return (v == {GCNT_W{1'b1}}) ? v : v + GCNT_W'(1);
  endfunction

endpackage

// File: rtl/coproc_sched_if.sv
// Requester, coprocessor and response signals of the scheduler.
// Grant counters exist only when COPROC_GNTCNT_EN is defined.
interface coproc_sched_if;
  import coproc_pkg::*;

  logic             req0_valid;
  logic             req1_valid;
  logic [RO_W-1:0]  req0_ro;
  logic [RO_W-1:0]  req1_ro;
  logic [CHK_W-1:0] req0_check;
  logic [CHK_W-1:0] req1_check;
  logic             req0_ready;
  logic             req1_ready;
  logic [RO_W-1:0]  cp_ro;
  logic [CHK_W-1:0] cp_check;
  logic             cp_q;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic             rsp_q;
  logic             busy;
`ifdef COPROC_GNTCNT_EN
  logic [GCNT_W-1:0] gnt_cnt0;
  logic [GCNT_W-1:0] gnt_cnt1;
`endif

  modport master (
`ifdef COPROC_GNTCNT_EN
    input  gnt_cnt0, gnt_cnt1,
`endif
    output req0_valid, req1_valid, req0_ro, req1_ro, req0_check, req1_check,
    output cp_q, rsp_ready,
    input  req0_ready, req1_ready, cp_ro, cp_check,
    input  rsp_valid, rsp_id, rsp_q, busy
  );

  modport slave (
`ifdef COPROC_GNTCNT_EN
    output gnt_cnt0, gnt_cnt1,
`endif
    input  req0_valid, req1_valid, req0_ro, req1_ro, req0_check, req1_check,
    input  cp_q, rsp_ready,
    output req0_ready, req1_ready, cp_ro, cp_check,
    output rsp_valid, rsp_id, rsp_q, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a tie goes to the requester that did not win last.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller gates the grants with its own readiness.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_id,
  output logic gnt0,
  output logic gnt1
);

  assign gnt0 = valid0 && (!valid1 || last_id);
  assign gnt1 = valid1 && (!valid0 || !last_id);

endmodule

// File: rtl/coproc_sched.sv
// Schedules two requesters onto one fixed-latency coprocessor, one op in flight.
// Latency: response valid LAT+1 cycles after acceptance; grants are combinational in IDLE.
// Backpressure: holds the response until rsp_ready; requesters see ready low while busy.
// Optional grant counters are built when COPROC_GNTCNT_EN is defined.
module coproc_sched
  import coproc_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  coproc_sched_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_id;
  op_t              cp_op;
  op_t              gnt_op;
  logic             rsp_id_r;
  logic             rsp_q_r;
  logic             arb_gnt0;
  logic             arb_gnt1;
  logic             acc0;
  logic             acc1;
  logic             accept;

  rr_arb2 u_arb (
    .valid0  (bus.req0_valid),
    .valid1  (bus.req1_valid),
    .last_id (last_id),
    .gnt0    (arb_gnt0),
    .gnt1    (arb_gnt1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grants are only offered in IDLE, so the response handshake cycle never overlaps a grant.
  always_comb begin
    state_nxt      = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.req0_ready = arb_gnt0;
        bus.req1_ready = arb_gnt1;
        if (arb_gnt0 || arb_gnt1) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign acc0   = bus.req0_valid && bus.req0_ready;
  assign acc1   = bus.req1_valid && bus.req1_ready;
  assign accept = acc0 || acc1;
  assign gnt_op = acc1 ? {bus.req1_ro, bus.req1_check} : {bus.req0_ro, bus.req0_check};

  always_ff @(posedge clk) begin
    if (reset) begin
      cp_op    <= '0;
      cnt      <= '0;
      last_id  <= 1'b1;
      rsp_id_r <= 1'b0;
      rsp_q_r  <= 1'b0;
    end else if (accept) begin
      cp_op    <= gnt_op;
      rsp_id_r <= acc1;
      last_id  <= acc1;
      cnt      <= CNT_W'(LAT - 1);
    end else if (state == WAIT) begin
      if (cnt == '0) begin
        rsp_q_r <= bus.cp_q;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign bus.cp_ro     = cp_op.ro;
  assign bus.cp_check  = cp_op.check;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_q     = rsp_q_r;
  assign bus.busy      = (state != IDLE);

`ifdef COPROC_GNTCNT_EN
  logic [GCNT_W-1:0] gnt_cnt0_r;
  logic [GCNT_W-1:0] gnt_cnt1_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt0_r <= '0;
      gnt_cnt1_r <= '0;
    end else begin
      if (acc0) gnt_cnt0_r <= sat_inc(gnt_cnt0_r);
      if (acc1) gnt_cnt1_r <= sat_inc(gnt_cnt1_r);
    end
  end

  assign bus.gnt_cnt0 = gnt_cnt0_r;
  assign bus.gnt_cnt1 = gnt_cnt1_r;
`endif

endmodule

// File: doc/coproc_sched.md
COPROC_SCHED -- requirements
Module: coproc_sched

Interface
REQ-001 SHALL have parameter LAT, default 2: co_processor result latency in clk cycles, legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1 each  requester N has an operation pending.
REQ-005 SHALL have ports req0_ro / req1_ro  input  8 each  ro operand of requester N.
REQ-006 SHALL have ports req0_check / req1_check  input  2 each  check code of requester N.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1 each  grant; request accepted when valid&&ready in the same cycle.
REQ-008 SHALL have port cp_ro  output  8  registered ro operand to co_processor.
REQ-009 SHALL have port cp_check  output  2  registered check code to co_processor.
REQ-010 SHALL have port cp_q  input  1  co_processor Q result.
REQ-011 SHALL have ports rsp_valid  output  1  response available; rsp_ready  input  1  consumer accepts.
REQ-012 SHALL have ports rsp_id  output  1  requester index of response; rsp_q  output  1  captured Q.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; one operation in flight at a time.
REQ-015 In IDLE, reqN_ready SHALL be combinational: single valid requester is granted; both valid -> requester != last_id granted; ready low for all in WAIT/RESP.
REQ-016 At most one reqN_ready SHALL be high in any cycle.
REQ-017 On acceptance, cp_ro/cp_check SHALL load the granted operands, rsp_id and last_id SHALL load the granted index, wait counter SHALL load LAT-1, state -> WAIT.
REQ-018 cp_ro/cp_check SHALL remain stable from the cycle after acceptance until the next acceptance.
REQ-019 In WAIT, counter SHALL decrement each cycle; in the WAIT cycle with counter==0, rsp_q SHALL capture cp_q and state -> RESP.
REQ-020 For acceptance in cycle c, rsp_valid SHALL first be high in cycle c+LAT+1.
REQ-021 In RESP, rsp_valid, rsp_id and rsp_q SHALL hold until rsp_valid&&rsp_ready; that cycle state -> IDLE; no new grant in that same cycle.
REQ-022 Requests arriving while busy SHALL wait (ready low) and are not dropped; requester must hold valid and operands.

Reset
REQ-023 reset SHALL force: state IDLE, cp_ro 0, cp_check 0, rsp_valid 0, rsp_id 0, rsp_q 0, busy 0, counter 0, last_id 1 (req0 wins first tie).
REQ-024 reset mid-operation SHALL abort the in-flight operation with no response issued; reset dominates all other inputs.

Configuration
REQ-025 With COPROC_GNTCNT_EN defined, SHALL add outputs gnt_cnt0 / gnt_cnt1 (8 bits each), incremented per acceptance of requester N, saturating at 255, reset to 0.
REQ-026 Without COPROC_GNTCNT_EN, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-027 Package coproc_pkg SHALL hold the FSM state enum, RO_W=8, CHK_W=2, LAT_DEFAULT=2.
REQ-028 Round-robin grant logic SHALL be sub-module rr_arb2 (2 valid in, last_id in, 2 grant out, combinational).

Verification
REQ-029 Single req0 (ro=8'hA5, check=2'b01), LAT=2 -> req0_ready same cycle c, cp_ro=A5/cp_check=01 from c+1, rsp_valid at c+3 with rsp_id=0, rsp_q = cp_q sampled at c+2.
REQ-030 req0 and req1 both valid from reset, rsp_ready tied high -> grant order 0,1,0,1; no grant while busy.
REQ-031 rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_id/rsp_q stable 5 cycles; req1 held valid meanwhile is not granted until cycle after handshake.
REQ-032 reset asserted in WAIT -> next cycle busy=0, rsp_valid=0, cp_ro=0; no response ever produced for aborted op.
REQ-033 LAT=1 and LAT=15 builds -> rsp_valid at c+2 and c+16 respectively.
REQ-034 With COPROC_GNTCNT_EN, 300 req1-only operations -> gnt_cnt1=255, gnt_cnt0=0.
